// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM block and its ramp controller.
package pwm_pkg;

   localparam int unsigned PWM_R          = 8;
   localparam int unsigned PWM_TIMER_BITS = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_HOLD = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/pwm_period_timer.sv
// Prescaler plus R-bit period counter; flags the last clock of every PWM period.
module pwm_period_timer
   import pwm_pkg::*;
#(
   parameter int unsigned R          = PWM_R,
   parameter int unsigned TIMER_BITS = PWM_TIMER_BITS
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic [TIMER_BITS-1:0] final_value,
   output logic                  period_tick
);

   logic [TIMER_BITS-1:0] r_presc;
   logic [R-1:0]          r_pcnt;
   logic                  w_wrap;

   // >= rather than == so a lowered final_value cannot strand the prescaler above it
   assign w_wrap      = (r_presc >= final_value);
   assign period_tick = w_wrap && (r_pcnt == {R{1'b1}});

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         r_presc <= '0;
         r_pcnt  <= '0;
      end else if (w_wrap) begin
         r_presc <= '0;
         r_pcnt  <= r_pcnt + R'(1);
      end else begin
         r_presc <= r_presc + TIMER_BITS'(1);
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps the PWM duty toward a requested target by a fixed step per PWM period.
module pwm_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int unsigned R          = PWM_R,
   parameter int unsigned TIMER_BITS = PWM_TIMER_BITS
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [TIMER_BITS-1:0] final_value,
   input  logic                  tgt_valid,
   output logic                  tgt_ready,
   input  logic [R:0]            tgt_duty,
   input  logic [R-1:0]          step,
   output logic [R:0]            duty,
   output logic                  period_tick,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned DW = R + 1;
   localparam logic [DW-1:0] DUTY_MAX = {1'b1, {R{1'b0}}};

   pwm_state_e     r_state, w_state_nxt;
   logic [DW-1:0]  r_duty, w_duty_nxt;
   logic [DW-1:0]  r_target, w_target_nxt;
   logic           r_done, w_done_nxt;
   logic           w_tick;
   logic           w_accept;
   logic           w_down;
   logic [DW-1:0]  w_diff;
   logic [DW-1:0]  w_step;

   pwm_period_timer #(
      .R          (R),
      .TIMER_BITS (TIMER_BITS)
   ) u_timer (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (!enable),
      .final_value (final_value),
      .period_tick (w_tick)
   );

   assign period_tick = w_tick;
   assign busy        = (r_state == ST_RAMP);
   assign tgt_ready   = reset_n && enable && (r_state != ST_RAMP);
   assign duty        = r_duty;
   assign done        = r_done;

   assign w_accept = tgt_valid && tgt_ready;
   assign w_down   = (r_duty > r_target);
   assign w_diff   = w_down ? (r_duty - r_target) : (r_target - r_duty);
   assign w_step   = {1'b0, step};

   // Duty only moves on a period boundary; the step is applied only when it cannot overshoot
   always_comb begin
      w_state_nxt  = r_state;
      w_duty_nxt   = r_duty;
      w_target_nxt = r_target;
      w_done_nxt   = 1'b0;
      if (!enable) begin
         w_state_nxt  = ST_IDLE;
         w_duty_nxt   = '0;
         w_target_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HOLD: begin
               if (w_accept) begin
                  w_target_nxt = (tgt_duty > DUTY_MAX) ? DUTY_MAX : tgt_duty;
                  w_state_nxt  = ST_RAMP;
               end
            end
            ST_RAMP: begin
               if (w_tick) begin
                  if ((step == '0) || (w_diff <= w_step)) begin
                     w_duty_nxt  = r_target;
                     w_state_nxt = ST_HOLD;
                     w_done_nxt  = 1'b1;
                  end else if (w_down) begin
                     w_duty_nxt = r_duty - w_step;
                  end else begin
                     w_duty_nxt = r_duty + w_step;
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_duty   <= '0;
         r_target <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_duty   <= w_duty_nxt;
         r_target <= w_target_nxt;
         r_done   <= w_done_nxt;
      end
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: per-period duty scoreboard plus abort and timing checks.
module tb_pwm_ramp_ctrl;

   localparam int unsigned R  = 8;
   localparam int unsigned TB = 10;

   logic          clk = 1'b0;
   logic          reset_n, enable, tgt_valid;
   logic [TB-1:0] final_value;
   logic [R:0]    tgt_duty;
   logic [R-1:0]  step;
   logic          tgt_ready, period_tick, busy, done;
   logic [R:0]    duty;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned done_cnt = 0;

   typedef struct {
      int unsigned duty;
      bit          done;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   pwm_ramp_ctrl #(.R(R), .TIMER_BITS(TB)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .final_value (final_value),
      .tgt_valid   (tgt_valid),
      .tgt_ready   (tgt_ready),
      .tgt_duty    (tgt_duty),
      .step        (step),
      .duty        (duty),
      .period_tick (period_tick),
      .busy        (busy),
      .done        (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int unsigned d, input bit dn);
      exp_t e;
      e.duty = d;
      e.done = dn;
      sb.push_back(e);
   endtask

   // Advance to the next negedge at which period_tick is high; elapsed counts clock edges
   task automatic wait_tick(input int unsigned budget, output int unsigned elapsed);
      int unsigned start;
      bit seen;
      start = cyc;
      seen  = 1'b0;
      for (int i = 0; i < int'(budget); i++) begin
         @(negedge clk);
         if (period_tick) begin
            seen = 1'b1;
            break;
         end
      end
      elapsed = cyc - start;
      check("tick_seen", 32'(seen), 32'd1);
   endtask

   task automatic drain(input int n, input string tag);
      int unsigned el;
      exp_t e;
      for (int k = 0; k < n; k++) begin
         wait_tick(2000, el);
         @(negedge clk);
         if (sb.size() == 0) begin
            check($sformatf("%s_sb_empty", tag), 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            check($sformatf("%s_duty%0d", tag, k), 32'(duty), e.duty);
            check($sformatf("%s_done%0d", tag, k), 32'(done), 32'(e.done));
         end
      end
   endtask

   task automatic offer(input int unsigned d, input int unsigned s);
      tgt_duty  = (R+1)'(d);
      step      = R'(s);
      tgt_valid = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
   endtask

   initial begin
      int unsigned el;
      int unsigned d0;
      reset_n = 1'b0; enable = 1'b1; tgt_valid = 1'b0;
      tgt_duty = '0; step = '0; final_value = TB'(1);
      repeat (3) @(negedge clk);
      check("rst_duty", 32'(duty), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_tick", 32'(period_tick), 32'd0);
      check("rst_ready", 32'(tgt_ready), 32'd0);
      reset_n = 1'b1;
      #1 check("ready_after_rst", 32'(tgt_ready), 32'd1);
      @(negedge clk);

      // ramp up 0 -> 128 by 32
      offer(128, 32);
      check("up_busy", 32'(busy), 32'd1);
      check("up_ready", 32'(tgt_ready), 32'd0);
      push(32, 0); push(64, 0); push(96, 0); push(128, 1);
      drain(4, "up");
      check("up_busy_after", 32'(busy), 32'd0);
      check("up_ready_after", 32'(tgt_ready), 32'd1);
      @(negedge clk);
      check("up_done_pulse", 32'(done), 32'd0);

      // ramp down with clamp; a target offered mid-ramp must be ignored
      offer(64, 48);
      tgt_duty = 9'd200; tgt_valid = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
      push(80, 0); push(64, 1);
      drain(2, "down");

      // step 0 jumps, 300 saturates to 256
      offer(300, 0);
      push(256, 1);
      drain(1, "jump");

      // target equal to current duty
      offer(256, 5);
      push(256, 1);
      drain(1, "same");

      // abort via enable at duty 64 mid-ramp
      offer(0, 64);
      push(192, 0); push(128, 0); push(64, 0);
      drain(3, "abort_ramp");
      check("abort_busy_pre", 32'(busy), 32'd1);
      d0 = done_cnt;
      enable = 1'b0;
      @(negedge clk);
      check("en_abort_duty", 32'(duty), 32'd0);
      check("en_abort_busy", 32'(busy), 32'd0);
      check("en_abort_ready", 32'(tgt_ready), 32'd0);
      repeat (600) @(negedge clk);
      check("en_abort_nodone", done_cnt, d0);
      check("en_abort_hold0", 32'(duty), 32'd0);

      // re-enable: first tick (1+1)*256 clocks after the enable cycle, i.e. 511 edges on
      enable = 1'b1; tgt_duty = 9'd128; step = 8'd64; tgt_valid = 1'b1;
      wait_tick(2000, el);
      check("en_first_tick", el, 32'd511);
      @(negedge clk);
      tgt_valid = 1'b0;
      check("reen_duty", 32'(duty), 32'd64);
      check("reen_busy", 32'(busy), 32'd1);

      // same abort via reset
      d0 = done_cnt;
      reset_n = 1'b0;
      @(negedge clk);
      check("rst_abort_duty", 32'(duty), 32'd0);
      check("rst_abort_busy", 32'(busy), 32'd0);
      check("rst_abort_ready", 32'(tgt_ready), 32'd0);
      check("rst_abort_nodone", done_cnt, d0);

      // final_value 0 -> tick every 256 clocks
      final_value = '0;
      reset_n = 1'b1;
      wait_tick(2000, el);
      wait_tick(2000, el);
      check("fv0_period_a", el, 32'd256);
      wait_tick(2000, el);
      check("fv0_period_b", el, 32'd256);

      // final_value 195 -> 50176-clock period, first tick on edge 50175 after enable
      enable = 1'b0;
      final_value = TB'(195);
      @(negedge clk);
      enable = 1'b1;
      wait_tick(60000, el);
      check("fv195_first_tick", el, 32'd50175);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
